// File: rtl/ama_riscv_decode_q_pkg.sv
// ama_riscv_decode_q_pkg: shared decode types, queue entry layout and opcode legality helper.
// Optional feature macro used by the queue: DECODE_Q_BYPASS_EN.
package ama_riscv_decode_q_pkg;
    typedef logic [31:0] arch_width_t;
    typedef enum logic [1:0] {ALU_A_RS1, ALU_A_PC, ALU_A_ZERO} alu_a_sel_t;
    typedef enum logic {ALU_B_RS2, ALU_B_IMM} alu_b_sel_t;
    typedef enum logic [2:0] {IG_DISABLED, I_TYPE, S_TYPE, B_TYPE, J_TYPE, U_TYPE} ig_sel_t;
    typedef enum logic [1:0] {WB_SEL_DMEM, WB_SEL_ALU, WB_SEL_INC4, WB_SEL_CSR} wb_sel_t;
    typedef enum logic {PC_SEL_INC4, PC_SEL_ALU} pc_sel_t;
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    typedef struct packed {
        logic [3:0]  alu_op;
        alu_a_sel_t  alu_a_sel;
        alu_b_sel_t  alu_b_sel;
        ig_sel_t     ig_sel;
        arch_width_t imm;
        wb_sel_t     wb_sel;
        logic        rd_we;
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic        dmem_en;
        logic        dmem_we;
        logic        csr_en;
        logic        branch;
        logic        jump;
    } decoded_t;
    typedef struct packed {
        logic    pc_we;
        pc_sel_t pc_sel;
    } fe_ctrl_t;
    typedef struct packed {
        decoded_t    decoded;
        fe_ctrl_t    fe_ctrl;
        arch_width_t inst;
        arch_width_t pc;
        logic        illegal;
    } decode_q_entry_t;
    localparam decoded_t DECODED_RST_VAL = '0;
    localparam fe_ctrl_t FE_CTRL_RST_VAL = '0;
    localparam decode_q_entry_t DECODE_Q_ENTRY_RST_VAL = '0;
    // Full 7-bit opcode match also rejects compressed encodings (inst[1:0] != 2'b11)
    function automatic logic opcode_legal(input logic [6:0] opc);
        return opc inside {OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                           OPC_JALR, OPC_JAL, OPC_LUI, OPC_AUIPC, OPC_SYSTEM};
    endfunction
endpackage

// File: rtl/ama_riscv_decoder.sv
// ama_riscv_decoder: combinational RV32I control decode; legality is merged by the caller.
module ama_riscv_decoder
    import ama_riscv_decode_q_pkg::*;
(
    input  arch_width_t inst,
    output decoded_t    decoded,
    output fe_ctrl_t    fe_ctrl
);
    logic [2:0] f3;
    assign f3 = inst[14:12];
    always_comb begin
        decoded = DECODED_RST_VAL;
        fe_ctrl = '{pc_we: 1'b1, pc_sel: PC_SEL_INC4};
        decoded.rd_addr = inst[11:7];
        decoded.rs1_addr = inst[19:15];
        decoded.rs2_addr = inst[24:20];
        case (inst[6:0])
            OPC_R: begin
                decoded.alu_op = {inst[30], f3};
                decoded.wb_sel = WB_SEL_ALU;
                decoded.rd_we = 1'b1;
            end
            OPC_I: begin
                decoded.alu_op = {(f3 == 3'b101) & inst[30], f3};
                decoded.alu_b_sel = ALU_B_IMM;
                decoded.ig_sel = I_TYPE;
                decoded.wb_sel = WB_SEL_ALU;
                decoded.rd_we = 1'b1;
            end
            OPC_LOAD: begin
                decoded.alu_b_sel = ALU_B_IMM;
                decoded.ig_sel = I_TYPE;
                decoded.wb_sel = WB_SEL_DMEM;
                decoded.rd_we = 1'b1;
                decoded.dmem_en = 1'b1;
            end
            OPC_STORE: begin
                decoded.alu_b_sel = ALU_B_IMM;
                decoded.ig_sel = S_TYPE;
                decoded.dmem_en = 1'b1;
                decoded.dmem_we = 1'b1;
            end
            OPC_BRANCH: begin
                decoded.alu_a_sel = ALU_A_PC;
                decoded.alu_b_sel = ALU_B_IMM;
                decoded.ig_sel = B_TYPE;
                decoded.branch = 1'b1;
            end
            OPC_JALR, OPC_JAL: begin
                decoded.alu_a_sel = inst[3] ? ALU_A_PC : ALU_A_RS1;
                decoded.alu_b_sel = ALU_B_IMM;
                decoded.ig_sel = inst[3] ? J_TYPE : I_TYPE;
                decoded.wb_sel = WB_SEL_INC4;
                decoded.rd_we = 1'b1;
                decoded.jump = 1'b1;
                fe_ctrl.pc_sel = PC_SEL_ALU;
            end
            OPC_LUI, OPC_AUIPC: begin
                decoded.alu_a_sel = inst[5] ? ALU_A_ZERO : ALU_A_PC;
                decoded.alu_b_sel = ALU_B_IMM;
                decoded.ig_sel = U_TYPE;
                decoded.wb_sel = WB_SEL_ALU;
                decoded.rd_we = 1'b1;
            end
            OPC_SYSTEM: begin
                decoded.wb_sel = WB_SEL_CSR;
                decoded.rd_we = 1'b1;
                decoded.csr_en = 1'b1;
            end
            default: ;
        endcase
        decoded.imm = (decoded.ig_sel == I_TYPE) ? {{20{inst[31]}}, inst[31:20]} :
                      (decoded.ig_sel == S_TYPE) ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                      (decoded.ig_sel == B_TYPE) ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
                      (decoded.ig_sel == J_TYPE) ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
                      (decoded.ig_sel == U_TYPE) ? {inst[31:12], 12'b0} : '0;
    end
endmodule

// File: rtl/ama_riscv_decode_q.sv
// ama_riscv_decode_q: in-order decode queue between fetch and issue with illegal-op flagging.
// Define DECODE_Q_BYPASS_EN for a zero-latency path through an empty queue.
module ama_riscv_decode_q
    import ama_riscv_decode_q_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  arch_width_t                in_inst,
    input  arch_width_t                in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output decode_q_entry_t            out_entry,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    logic [PW-1:0] wr_ptr, rd_ptr;
    decode_q_entry_t mem [DEPTH];
    decode_q_entry_t live;
    decoded_t dec;
    fe_ctrl_t fe;
    logic rdy_en, illegal, push, pop, wr_en, rd_en;
    ama_riscv_decoder u_decoder (.inst(in_inst), .decoded(dec), .fe_ctrl(fe));
    assign illegal = !opcode_legal(in_inst[6:0]);
    assign live = '{decoded: illegal ? DECODED_RST_VAL : dec,
                    fe_ctrl: illegal ? FE_CTRL_RST_VAL : fe,
                    inst: in_inst, pc: in_pc, illegal: illegal};
    // rdy_en keeps in_ready low until the first edge after reset release
    assign in_ready = rdy_en && (level != LW'(DEPTH));
    assign push = in_valid && in_ready;
    assign pop = out_valid && out_ready;
`ifdef DECODE_Q_BYPASS_EN
    logic byp;
    assign byp = rdy_en && (level == '0) && !flush;
    assign out_valid = byp ? in_valid : (level != '0);
    assign out_entry = byp ? live : mem[rd_ptr];
    assign wr_en = push && !(byp && out_ready);
    assign rd_en = pop && !byp;
`else
    assign out_valid = level != '0;
    assign out_entry = mem[rd_ptr];
    assign wr_en = push;
    assign rd_en = pop;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level <= '0;
            end else begin
                wr_ptr <= wr_ptr + PW'(wr_en);
                rd_ptr <= rd_ptr + PW'(rd_en);
                level <= level + LW'(wr_en) - LW'(rd_en);
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DECODE_Q_ENTRY_RST_VAL;
        end else if (wr_en && !flush) begin
            mem[wr_ptr] <= live;
        end
    end
endmodule
